pong_game_ctrl: RTL
===================

# pong_game_ctrl

Match sequencer for the Pong datapath. Drives the 32-bit `ctrl` word that runs or freezes the ball mover. Compares the ball position with both paddles at each contact column to detect hits and misses. Keeps both scores, inserts a serve delay after every point and ends the match at a configurable winning score. Sits between the user-input/button logic and the ball and paddle movers; feeds scores to the display overlay.

## Interface
- SCREEN_WIDTH, 640, horizontal resolution (px)
- PADDLE_X_1, 19, left paddle left-edge column
- PADDLE_X_2, 616, right paddle left-edge column
- PADDLE_WIDTH, 5, paddle width (px)
- PADDLE_HEIGHT, 60, paddle height (px)
- BALL_SIZE, 10, ball width/height (px)
- SERVE_DELAY, 50_000_000, cycles the ball is held centred before each serve (≥0)
- WIN_SCORE, 7, points to win (1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse (already debounced/synchronised)
- ball_x  in  10  ball left column
- ball_y  in  9  ball top row
- paddle1_y  in  9  left paddle top row
- paddle2_y  in  9  right paddle top row
- ctrl  out  32  bit0 = run ball; bits 31:1 always 0
- score1  out  4  left player score
- score2  out  4  right player score
- winner  out  2  0 none, 1 left, 2 right
- hit  out  1  one-cycle pulse on a paddle contact
- state  out  3  current FSM state (debug)

## Operation
- States: IDLE(0), SERVE(1), PLAY(2), POINT(3), OVER(4).
- IDLE: ctrl=0. On start: scores←0, winner←0, serve counter←0, go to SERVE.
- SERVE: ctrl=0, so the ball mover recentres. Counter increments each cycle. When counter==SERVE_DELAY, go to PLAY.
- PLAY: ctrl=1.
- Left contact column: L = PADDLE_X_1+PADDLE_WIDTH−1 (23).
- Right contact column: R = PADDLE_X_2−BALL_SIZE+1 (607).
- Overlap with paddle p: ball_y+BALL_SIZE > pN_y AND ball_y < pN_y+PADDLE_HEIGHT. Compute at 11-bit width; no wrap.
- Contact event: ball_x differs from its registered previous value and the new value equals L or R. This is detected once per arrival, not every cycle the ball dwells there.
- Contact with overlap: pulse hit, stay in PLAY.
- Contact without overlap: this is a miss. Miss at L scores for right (score2+1); miss at R scores for left (score1+1). Go to POINT.
- POINT (1 cycle): ctrl=0. If the incremented score == WIN_SCORE, set winner and go to OVER. Otherwise clear the counter and go to SERVE.
- OVER: ctrl=0; scores and winner are held. On start: clear scores and winner, go to SERVE.
- start is ignored in SERVE, PLAY and POINT.
- Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered.
- Reset values: ctrl=0, score1=score2=0, winner=0, hit=0, state=IDLE, serve counter=0, previous-x register=ball_x reset centre (SCREEN_WIDTH/2−1).
- start → SERVE: 1 cycle.
- SERVE lasts SERVE_DELAY+1 cycles. With SERVE_DELAY=0 it lasts exactly 1 cycle.
- Contact detected at cycle n → hit high at n+1 (1 cycle), or state=POINT at n+1 with score updated at n+1.
- POINT → SERVE/OVER: next cycle. ctrl drops to 0 in the cycle after the miss is detected.
- Reset mid-match: returns to IDLE on the next edge and zeroes all scores.
- The serve counter is 26 bits and saturates at SERVE_DELAY.

## Configuration
- PONG_ATTRACT_MODE_EN defined:
  - IDLE drives ctrl=1, so the ball bounces as a demo.
  - Contacts still pulse hit; misses are ignored (no scoring, no state change).
  - start behaves as normal.
- PONG_ATTRACT_MODE_EN undefined: IDLE drives ctrl=0.

## Structure
- Shared package pong_pkg:
  - state encodings (IDLE..OVER)
  - winner codes
  - screen/field constants shared with the ball mover and paddle movers
- Sub-module pong_contact, instantiated twice (left, right):
  - inputs: ball_x, ball_y, paddle_y, contact column
  - outputs: contact, overlap
  - parameterised by PADDLE_HEIGHT and BALL_SIZE
- Remaining logic in the top: FSM, serve counter, scores, previous-x register.

## Test plan
Bench parameters: SERVE_DELAY=4, WIN_SCORE=2, attract macro undefined unless noted.
1. Reset, then start pulse → state=1 for 5 cycles with ctrl=0, then state=2 and ctrl=1.
2. In PLAY, ball_x 24→23 with ball_y=100, paddle1_y=95 → hit=1 for one cycle, scores unchanged. Hold ball_x=23 for 10 cycles → no further hit.
3. In PLAY, ball_x 606→607 with ball_y=100, paddle2_y=300 → score1=1, state 3 then 1, ctrl=0 from the next cycle.
4. Two left misses (ball_x→23, paddle1_y=300) → score2=2, winner=2, state=4. A further ball_x change → no score change. Start → scores 0, state=1.
5. Reset asserted in PLAY with score1=1 → next cycle state=0, score1=0, ctrl=0.
6. With PONG_ATTRACT_MODE_EN: after reset ctrl=1 in IDLE; a miss at 23 → scores stay 0, state stays 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state encodings, winner codes and field constants
// used by the match sequencer, ball mover and paddle movers.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'd0,
        WIN_LEFT  = 2'd1,
        WIN_RIGHT = 2'd2
    } winner_t;

    localparam int SCREEN_WIDTH_DEF  = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;
    localparam int PADDLE_X_1_DEF    = 19;
    localparam int PADDLE_X_2_DEF    = 616;
    localparam int PADDLE_WIDTH_DEF  = 5;
    localparam int PADDLE_HEIGHT_DEF = 60;
    localparam int BALL_SIZE_DEF     = 10;

endpackage

// File: rtl/pong_contact.sv
// Paddle contact detector: flags the ball sitting on a contact column and
// whether its rows overlap the paddle. Overlap math is 11 bits wide so it never wraps.
module pong_contact #(
    parameter int PADDLE_HEIGHT = 60,
    parameter int BALL_SIZE     = 10
) (
    input  logic [9:0] i_ball_x,
    input  logic [8:0] i_ball_y,
    input  logic [8:0] i_paddle_y,
    input  logic [9:0] i_col,
    output logic       o_contact,
    output logic       o_overlap
);

    logic [10:0] w_ball_bot;
    logic [10:0] w_pad_bot;

    assign w_ball_bot = {2'b00, i_ball_y} + 11'(BALL_SIZE);
    assign w_pad_bot  = {2'b00, i_paddle_y} + 11'(PADDLE_HEIGHT);

    assign o_contact = (i_ball_x == i_col);
    assign o_overlap = (w_ball_bot > {2'b00, i_paddle_y}) &&
                       ({2'b00, i_ball_y} < w_pad_bot);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve delay, hit/miss detection, scoring and match end.
// Optional feature macro: PONG_ATTRACT_MODE_EN (ball runs as a demo while IDLE).
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int PADDLE_X_1    = PADDLE_X_1_DEF,
    parameter int PADDLE_X_2    = PADDLE_X_2_DEF,
    parameter int PADDLE_WIDTH  = PADDLE_WIDTH_DEF,
    parameter int PADDLE_HEIGHT = PADDLE_HEIGHT_DEF,
    parameter int BALL_SIZE     = BALL_SIZE_DEF,
    parameter int SERVE_DELAY   = 50_000_000,
    parameter int WIN_SCORE     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [9:0]  i_ball_x,
    input  logic [8:0]  i_ball_y,
    input  logic [8:0]  i_paddle1_y,
    input  logic [8:0]  i_paddle2_y,
    output logic [31:0] o_ctrl,
    output logic [3:0]  o_score1,
    output logic [3:0]  o_score2,
    output logic [1:0]  o_winner,
    output logic        o_hit,
    output logic [2:0]  o_state
);

    localparam logic [9:0]  COL_L    = 10'(PADDLE_X_1 + PADDLE_WIDTH - 1);
    localparam logic [9:0]  COL_R    = 10'(PADDLE_X_2 - BALL_SIZE + 1);
    localparam logic [9:0]  X_CENTRE = 10'(SCREEN_WIDTH / 2 - 1);
    localparam logic [25:0] SD       = 26'(SERVE_DELAY);
    localparam logic [3:0]  WIN4     = 4'(WIN_SCORE);

    state_t      r_state, w_nx_state;
    winner_t     r_winner, w_nx_winner;
    logic [25:0] r_cnt, w_nx_cnt;
    logic [9:0]  r_prev_x;
    logic [3:0]  r_score1, r_score2, w_nx_score1, w_nx_score2;
    logic        r_hit, w_nx_hit;
    logic        r_run, w_nx_run;

    logic w_con_l, w_ov_l, w_con_r, w_ov_r;
    logic w_moved, w_ev_l, w_ev_r;

    pong_contact #(.PADDLE_HEIGHT(PADDLE_HEIGHT), .BALL_SIZE(BALL_SIZE)) u_contact_l (
        .i_ball_x  (i_ball_x),
        .i_ball_y  (i_ball_y),
        .i_paddle_y(i_paddle1_y),
        .i_col     (COL_L),
        .o_contact (w_con_l),
        .o_overlap (w_ov_l)
    );

    pong_contact #(.PADDLE_HEIGHT(PADDLE_HEIGHT), .BALL_SIZE(BALL_SIZE)) u_contact_r (
        .i_ball_x  (i_ball_x),
        .i_ball_y  (i_ball_y),
        .i_paddle_y(i_paddle2_y),
        .i_col     (COL_R),
        .o_contact (w_con_r),
        .o_overlap (w_ov_r)
    );

    // A contact only counts on the cycle the ball arrives at the column.
    assign w_moved = (i_ball_x != r_prev_x);
    assign w_ev_l  = w_moved && w_con_l;
    assign w_ev_r  = w_moved && w_con_r;

    // Next-state, counter, score, winner and registered-output decode.
    always_comb begin
        w_nx_state  = r_state;
        w_nx_cnt    = r_cnt;
        w_nx_score1 = r_score1;
        w_nx_score2 = r_score2;
        w_nx_winner = r_winner;
        w_nx_hit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
`ifdef PONG_ATTRACT_MODE_EN
                if ((w_ev_l && w_ov_l) || (w_ev_r && w_ov_r))
                    w_nx_hit = 1'b1;
`endif
                if (i_start) begin
                    w_nx_score1 = '0;
                    w_nx_score2 = '0;
                    w_nx_winner = WIN_NONE;
                    w_nx_cnt    = '0;
                    w_nx_state  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (r_cnt == SD)
                    w_nx_state = ST_PLAY;
                else
                    w_nx_cnt = r_cnt + 26'd1;
            end
            ST_PLAY: begin
                if (w_ev_l) begin
                    if (w_ov_l) begin
                        w_nx_hit = 1'b1;
                    end else begin
                        w_nx_score2 = r_score2 + 4'd1;
                        w_nx_state  = ST_POINT;
                    end
                end else if (w_ev_r) begin
                    if (w_ov_r) begin
                        w_nx_hit = 1'b1;
                    end else begin
                        w_nx_score1 = r_score1 + 4'd1;
                        w_nx_state  = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (r_score1 == WIN4) begin
                    w_nx_winner = WIN_LEFT;
                    w_nx_state  = ST_OVER;
                end else if (r_score2 == WIN4) begin
                    w_nx_winner = WIN_RIGHT;
                    w_nx_state  = ST_OVER;
                end else begin
                    w_nx_cnt   = '0;
                    w_nx_state = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (i_start) begin
                    w_nx_score1 = '0;
                    w_nx_score2 = '0;
                    w_nx_winner = WIN_NONE;
                    w_nx_cnt    = '0;
                    w_nx_state  = ST_SERVE;
                end
            end
            default: w_nx_state = ST_IDLE;
        endcase
`ifdef PONG_ATTRACT_MODE_EN
        w_nx_run = (w_nx_state == ST_PLAY) || (w_nx_state == ST_IDLE);
`else
        w_nx_run = (w_nx_state == ST_PLAY);
`endif
    end

    // State, counters, scores and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_prev_x <= X_CENTRE;
            r_score1 <= '0;
            r_score2 <= '0;
            r_winner <= WIN_NONE;
            r_hit    <= 1'b0;
            r_run    <= 1'b0;
        end else begin
            r_state  <= w_nx_state;
            r_cnt    <= w_nx_cnt;
            r_prev_x <= i_ball_x;
            r_score1 <= w_nx_score1;
            r_score2 <= w_nx_score2;
            r_winner <= w_nx_winner;
            r_hit    <= w_nx_hit;
            r_run    <= w_nx_run;
        end
    end

    assign o_ctrl   = {31'd0, r_run};
    assign o_score1 = r_score1;
    assign o_score2 = r_score2;
    assign o_winner = r_winner;
    assign o_hit    = r_hit;
    assign o_state  = r_state;

endmodule
